// File: rtl/tl_ul_ram_responder.sv
// TileLink-UL manager backed by a word RAM, answering Get/PutFull/PutPartial
// in request order through a small response FIFO with a minimum D latency.
package tl_ul_ram_responder_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned AGE_W  = 4;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } rsp_t;
endpackage

module tl_ul_ram_responder
  import tl_ul_ram_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       LATENCY     = 1,
  parameter int unsigned       QDEPTH      = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [SIZE_W-1:0] a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [MASK_W-1:0] a_mask,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_corrupt,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [SIZE_W-1:0] d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_sink,
  output logic              d_denied,
  output logic [DATA_W-1:0] d_data,
  output logic              d_corrupt
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam logic [AGE_W-1:0] LAT = AGE_W'(LATENCY);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [DATA_W-1:0] ram [DEPTH_WORDS];
  rsp_t              fifo_q [QDEPTH];

  logic [QDEPTH-1:0][AGE_W-1:0] age_q, age_d, age_inc;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             a_ready_q, a_ready_d;
  logic             d_valid_q, d_valid_d;
  rsp_t             d_rsp_q, d_rsp_d;

  logic [ADDR_W:0]   addr_diff;
  logic [IDX_W-1:0]  word_idx;
  logic              misaligned, out_of_range, bad_opcode, denied, is_get;
  logic              a_fire, d_fire, wr_en;
  logic [DATA_W-1:0] byte_en, wr_word;
  rsp_t              new_rsp, head_next;

  // Poisoned write data is stored as-is and acknowledged without corrupt.
  logic unused_a_corrupt;
  assign unused_a_corrupt = a_corrupt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar g = 0; g < QDEPTH; g++) begin : g_age
    assign age_inc[g] = (age_q[g] == AGE_MAX) ? AGE_MAX : age_q[g] + AGE_W'(1);
  end

  // Request decode: the borrow bit of addr_diff makes below-base addresses out of range.
  always_comb begin
    addr_diff    = {1'b0, a_address} - {1'b0, BASE_ADDR};
    word_idx     = IDX_W'(addr_diff >> 2);
    out_of_range = (addr_diff >> 2) >= (ADDR_W + 1)'(DEPTH_WORDS);
    is_get       = (a_opcode == 3'd4);
    bad_opcode   = !((a_opcode == 3'd0) || (a_opcode == 3'd1) || is_get);
    case (a_size)
      4'd0:    misaligned = 1'b0;
      4'd1:    misaligned = a_address[0];
      4'd2:    misaligned = |a_address[1:0];
      default: misaligned = 1'b1;
    endcase
    denied  = bad_opcode | (a_param != 3'd0) | misaligned | out_of_range;
    a_fire  = a_valid & a_ready_q & ~reset;
    d_fire  = d_valid_q & d_ready;
    wr_en   = a_fire & ~denied & ~is_get;
    byte_en = {{8{a_mask[3]}}, {8{a_mask[2]}}, {8{a_mask[1]}}, {8{a_mask[0]}}};
    wr_word = (ram[word_idx] & ~byte_en) | (a_data & byte_en);

    new_rsp         = '0;
    new_rsp.opcode  = is_get ? 3'd1 : 3'd0;
    new_rsp.size    = a_size;
    new_rsp.source  = a_source;
    new_rsp.denied  = denied;
    new_rsp.data    = (is_get && !denied) ? ram[word_idx] : '0;
    new_rsp.corrupt = is_get & denied;
  end

  // FIFO bookkeeping and next D beat, registered so outputs hold until d_ready.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    age_d    = age_inc;
    if (a_fire) begin
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      age_d[wr_ptr_q] = '0;
    end
    if (d_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({a_fire, d_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head_next = (a_fire && (wr_ptr_q == rd_ptr_d)) ? new_rsp : fifo_q[rd_ptr_d];
    a_ready_d = count_d < CNT_W'(QDEPTH);
    d_valid_d = (count_d != '0) && (age_d[rd_ptr_d] >= LAT);
    d_rsp_d   = d_valid_d ? head_next : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      a_ready_q <= 1'b0;
      d_valid_q <= 1'b0;
      d_rsp_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      a_ready_q <= a_ready_d;
      d_valid_q <= d_valid_d;
      d_rsp_q   <= d_rsp_d;
    end
  end

  // Storage without reset: RAM contents survive reset, FIFO slots are rewritten on use.
  always_ff @(posedge clock) begin
    if (wr_en) ram[word_idx] <= wr_word;
    if (a_fire) fifo_q[wr_ptr_q] <= new_rsp;
  end

  assign a_ready   = a_ready_q;
  assign d_valid   = d_valid_q;
  assign d_opcode  = d_rsp_q.opcode;
  assign d_param   = 2'b00;
  assign d_size    = d_rsp_q.size;
  assign d_source  = d_rsp_q.source;
  assign d_sink    = 1'b0;
  assign d_denied  = d_rsp_q.denied;
  assign d_data    = d_rsp_q.data;
  assign d_corrupt = d_rsp_q.corrupt;

endmodule
